// File: rtl/amdc_analog_axil_regbank_if.sv
`default_nettype none
// ============================================================================
//  Module   : amdc_analog_axil_regbank_if
//  Brief    : AXI4-Lite bundle between the PS interconnect and the analog
//             front-end register bank (slave = register bank).
//  Revision : 1.0  initial release
// ============================================================================
interface amdc_analog_axil_regbank_if #(
   parameter int ADDR_WIDTH = 7
);
   // Write address / data / response
   logic [ADDR_WIDTH-1:0] AWADDR;
   logic                  AWVALID;
   logic                  AWREADY;
   logic [31:0]           WDATA;
   logic [3:0]            WSTRB;
   logic                  WVALID;
   logic                  WREADY;
   logic [1:0]            BRESP;
   logic                  BVALID;
   logic                  BREADY;
   // Read address / data
   logic [ADDR_WIDTH-1:0] ARADDR;
   logic                  ARVALID;
   logic                  ARREADY;
   logic [31:0]           RDATA;
   logic [1:0]            RRESP;
   logic                  RVALID;
   logic                  RREADY;

   modport slave (
      input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport master (
      output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );
endinterface
`default_nettype wire

// File: rtl/amdc_analog_axil_regbank.sv
`default_nettype none
// ============================================================================
//  Module   : amdc_analog_axil_regbank
//  Brief    : AXI4-Lite register bank for the analog front end. Captures one
//             sample per channel on each sample_valid strobe and exposes the
//             samples, CTRL, DIV, STATUS (W1C) and a capture counter.
//  Revision : 1.0  initial release
// ============================================================================
module amdc_analog_axil_regbank #(
   parameter int NUM_CH       = 8,
   parameter int SAMPLE_WIDTH = 16,
   parameter int ADDR_WIDTH   = 7
) (
   input  logic                             ACLK,
   input  logic                             ARESET,
   amdc_analog_axil_regbank_if.slave        S_AXI,
   input  logic                             sample_valid,
   input  logic [NUM_CH*SAMPLE_WIDTH-1:0]   sample_data,
   output logic                             enable_out,
   output logic [15:0]                      divider_out,
   output logic                             irq
);

   // Word indices of the register map; channels follow STATUS/SEQ.
   localparam logic [31:0] C_IDX_CTRL   = 32'd0;
   localparam logic [31:0] C_IDX_DIV    = 32'd1;
   localparam logic [31:0] C_IDX_STATUS = 32'd2;
   localparam logic [31:0] C_IDX_SEQ    = 32'd3;
   localparam logic [31:0] C_IDX_CH0    = 32'd4;
   localparam logic [31:0] C_NUM_WORDS  = 32'(4 + NUM_CH);
   localparam logic [1:0]  C_RESP_OKAY  = 2'b00;
   localparam logic [1:0]  C_RESP_SLVERR = 2'b10;
   localparam logic [15:0] C_DIV_RESET  = 16'd10;

   typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
   typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

   // ------------------------------------------------------------------------
   // Register state
   // ------------------------------------------------------------------------
   logic [2:0]              ctrl_q,   ctrl_d;     // [0] enable [1] freeze [2] irq_en
   logic [15:0]             div_q,    div_d;
   logic                    new_q,    new_d;
   logic                    ovr_q,    ovr_d;
   logic [31:0]             seq_q,    seq_d;
   logic                    irq_q;
   logic [SAMPLE_WIDTH-1:0] ch_q [NUM_CH];
   logic [31:0]             w_ch_ext [NUM_CH];

   w_state_t                w_state_q, w_state_d;
   r_state_t                r_state_q, r_state_d;
   logic                    w_wr_accept;
   logic                    w_rd_accept;
   logic [1:0]              bresp_q;
   logic [31:0]             rdata_q,  rdata_d;
   logic [1:0]              rresp_q,  rresp_d;

   logic [31:0]             w_widx;
   logic [31:0]             w_ridx;
   logic                    w_capture;
   logic                    w_unused;

   assign w_widx    = 32'(S_AXI.AWADDR[ADDR_WIDTH-1:2]);
   assign w_ridx    = 32'(S_AXI.ARADDR[ADDR_WIDTH-1:2]);
   // Capture is gated by the registered CTRL value, so a CTRL write in the
   // same cycle as a strobe only affects later strobes.
   assign w_capture = sample_valid && ctrl_q[0] && !ctrl_q[1];

   // Byte lanes above DIV and the sub-word address bits carry no state.
   assign w_unused  = ^{S_AXI.WDATA[31:16], S_AXI.WSTRB[3:2],
                        S_AXI.AWADDR[1:0], S_AXI.ARADDR[1:0]};

   // Sign-extend each stored sample to the 32-bit bus width.
   for (genvar k = 0; k < NUM_CH; k++) begin : g_ext
      assign w_ch_ext[k] = 32'($signed(ch_q[k]));
   end

   // ------------------------------------------------------------------------
   // Write channel FSM
   // ------------------------------------------------------------------------
   // Write FSM state register.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) w_state_q <= W_IDLE;
      else        w_state_q <= w_state_d;
   end

   // Write FSM next state; AW/W are accepted together only while no response is pending.
   always_comb begin
      w_state_d   = w_state_q;
      w_wr_accept = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (S_AXI.AWVALID && S_AXI.WVALID && !ARESET) begin
               w_wr_accept = 1'b1;
               w_state_d   = W_RESP;
            end
         end
         W_RESP: begin
            if (S_AXI.BREADY) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   assign S_AXI.AWREADY = w_wr_accept;
   assign S_AXI.WREADY  = w_wr_accept;
   assign S_AXI.BVALID  = (w_state_q == W_RESP);
   assign S_AXI.BRESP   = bresp_q;

   // Latch the write response code at the accepting edge.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET)           bresp_q <= C_RESP_OKAY;
      else if (w_wr_accept) bresp_q <= (w_widx < C_NUM_WORDS) ? C_RESP_OKAY : C_RESP_SLVERR;
   end

   // ------------------------------------------------------------------------
   // Read channel FSM
   // ------------------------------------------------------------------------
   // Read FSM state register.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) r_state_q <= R_IDLE;
      else        r_state_q <= r_state_d;
   end

   // Read FSM next state; one outstanding read, held until RREADY.
   always_comb begin
      r_state_d   = r_state_q;
      w_rd_accept = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            if (S_AXI.ARVALID && !ARESET) begin
               w_rd_accept = 1'b1;
               r_state_d   = R_DATA;
            end
         end
         R_DATA: begin
            if (S_AXI.RREADY) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   assign S_AXI.ARREADY = w_rd_accept;
   assign S_AXI.RVALID  = (r_state_q == R_DATA);
   assign S_AXI.RDATA   = rdata_q;
   assign S_AXI.RRESP   = rresp_q;

   // Read mux over the current (pre-update) register values.
   always_comb begin
      rdata_d = 32'd0;
      rresp_d = C_RESP_OKAY;
      if (w_ridx == C_IDX_CTRL) begin
         rdata_d = {29'd0, ctrl_q};
      end else if (w_ridx == C_IDX_DIV) begin
         rdata_d = {16'd0, div_q};
      end else if (w_ridx == C_IDX_STATUS) begin
         rdata_d = {30'd0, ovr_q, new_q};
      end else if (w_ridx == C_IDX_SEQ) begin
         rdata_d = seq_q;
      end else if (w_ridx < C_NUM_WORDS) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (w_ridx == C_IDX_CH0 + 32'(k)) rdata_d = w_ch_ext[k];
         end
      end else begin
         rresp_d = C_RESP_SLVERR;
      end
   end

   // Read data/response register, loaded only on the accepting edge.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         rdata_q <= 32'd0;
         rresp_q <= C_RESP_OKAY;
      end else if (w_rd_accept) begin
         rdata_q <= rdata_d;
         rresp_q <= rresp_d;
      end
   end

   // ------------------------------------------------------------------------
   // Register bank
   // ------------------------------------------------------------------------
   // Next-state of CTRL/DIV/STATUS/SEQ: bus writes first, then capture so a
   // capture's status set overrides a simultaneous W1C.
   always_comb begin
      ctrl_d = ctrl_q;
      div_d  = div_q;
      new_d  = new_q;
      ovr_d  = ovr_q;
      seq_d  = seq_q;
      if (w_wr_accept && S_AXI.WSTRB[0] && (w_widx == C_IDX_CTRL)) begin
         ctrl_d = S_AXI.WDATA[2:0];
      end
      if (w_wr_accept && (w_widx == C_IDX_DIV)) begin
         if (S_AXI.WSTRB[0]) div_d[7:0]  = S_AXI.WDATA[7:0];
         if (S_AXI.WSTRB[1]) div_d[15:8] = S_AXI.WDATA[15:8];
      end
      if (w_wr_accept && S_AXI.WSTRB[0] && (w_widx == C_IDX_STATUS)) begin
         if (S_AXI.WDATA[0]) new_d = 1'b0;
         if (S_AXI.WDATA[1]) ovr_d = 1'b0;
      end
      if (w_capture) begin
         seq_d = seq_q + 32'd1;
         new_d = 1'b1;
         if (new_q) ovr_d = 1'b1;
      end
   end

   // CTRL/DIV/STATUS/SEQ and irq registers.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         ctrl_q <= 3'd0;
         div_q  <= C_DIV_RESET;
         new_q  <= 1'b0;
         ovr_q  <= 1'b0;
         seq_q  <= 32'd0;
         irq_q  <= 1'b0;
      end else begin
         ctrl_q <= ctrl_d;
         div_q  <= div_d;
         new_q  <= new_d;
         ovr_q  <= ovr_d;
         seq_q  <= seq_d;
         irq_q  <= new_q && ctrl_q[2];
      end
   end

   // Channel sample registers; all channels latch together on a capture.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         for (int k = 0; k < NUM_CH; k++) ch_q[k] <= '0;
      end else if (w_capture) begin
         for (int k = 0; k < NUM_CH; k++) ch_q[k] <= sample_data[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      end
   end

   assign enable_out  = ctrl_q[0];
   assign divider_out = div_q;
   assign irq         = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_amdc_analog_axil_regbank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_amdc_analog_axil_regbank
//  Brief    : Self-checking bench for the analog front-end register bank.
//  Revision : 1.0  initial release
// ============================================================================
module tb_amdc_analog_axil_regbank;
   localparam int NUM_CH = 8;
   localparam int SW     = 16;
   localparam int AW     = 7;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 sample_valid;
   logic [NUM_CH*SW-1:0] sample_data;
   logic                 enable_out;
   logic [15:0]          divider_out;
   logic                 irq;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   amdc_analog_axil_regbank_if #(.ADDR_WIDTH(AW)) axi ();

   amdc_analog_axil_regbank #(
      .NUM_CH(NUM_CH), .SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW)
   ) dut (
      .ACLK(clk), .ARESET(rst), .S_AXI(axi.slave),
      .sample_valid(sample_valid), .sample_data(sample_data),
      .enable_out(enable_out), .divider_out(divider_out), .irq(irq)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [2:0]    m_ctrl;
   logic [15:0]   m_div;
   logic          m_new, m_ovr, m_irq;
   logic [31:0]   m_seq;
   logic [SW-1:0] m_ch [NUM_CH];
   logic          m_bpend, m_rpend;
   logic [1:0]    m_bresp, m_rresp;
   logic [31:0]   m_rdata;
   logic [2:0]    o_ctrl;
   logic          o_new, m_wr;

   function automatic logic [1:0] mresp(input logic [AW-1:0] a);
      return ((int'(a) / 4) < 4 + NUM_CH) ? 2'b00 : 2'b10;
   endfunction

   function automatic logic [31:0] mread(input logic [AW-1:0] a);
      int w = int'(a) / 4;
      int v;
      if (w == 0) return 32'(m_ctrl);
      if (w == 1) return 32'(m_div);
      if (w == 2) return 32'(m_ovr) * 2 + 32'(m_new);
      if (w == 3) return m_seq;
      if (w < 4 + NUM_CH) begin
         v = int'(m_ch[w-4]);
         if (v >= 2**(SW-1)) v = v - 2**SW;
         return 32'(v);
      end
      return 32'd0;
   endfunction

   // Model advances on the same edges as the design, from bench-driven inputs only.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ctrl = 3'd0; m_div = 16'd10; m_new = 1'b0; m_ovr = 1'b0; m_seq = 32'd0;
         for (int k = 0; k < NUM_CH; k++) m_ch[k] = '0;
         m_irq = 1'b0; m_bpend = 1'b0; m_rpend = 1'b0;
         m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = 32'd0;
      end else begin
         o_ctrl = m_ctrl;
         o_new  = m_new;
         if (m_rpend) begin
            if (axi.RREADY) m_rpend = 1'b0;
         end else if (axi.ARVALID) begin
            m_rpend = 1'b1;
            m_rdata = mread(axi.ARADDR);
            m_rresp = mresp(axi.ARADDR);
         end
         m_wr = 1'b0;
         if (m_bpend) begin
            if (axi.BREADY) m_bpend = 1'b0;
         end else if (axi.AWVALID && axi.WVALID) begin
            m_bpend = 1'b1;
            m_bresp = mresp(axi.AWADDR);
            m_wr    = 1'b1;
         end
         if (m_wr) begin
            case (int'(axi.AWADDR) / 4)
               0: if (axi.WSTRB[0]) m_ctrl = axi.WDATA[2:0];
               1: begin
                  if (axi.WSTRB[0]) m_div[7:0]  = axi.WDATA[7:0];
                  if (axi.WSTRB[1]) m_div[15:8] = axi.WDATA[15:8];
               end
               2: if (axi.WSTRB[0]) begin
                  if (axi.WDATA[0]) m_new = 1'b0;
                  if (axi.WDATA[1]) m_ovr = 1'b0;
               end
               default: ;
            endcase
         end
         if (sample_valid && o_ctrl[0] && !o_ctrl[1]) begin
            if (o_new) m_ovr = 1'b1;
            m_new = 1'b1;
            m_seq = m_seq + 32'd1;
            for (int k = 0; k < NUM_CH; k++) m_ch[k] = sample_data[k*SW +: SW];
         end
         m_irq = o_new && o_ctrl[2];
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      chk("enable_out",  32'(enable_out),  32'(m_ctrl[0]));
      chk("divider_out", 32'(divider_out), 32'(m_div));
      chk("irq",         32'(irq),         32'(m_irq));
      chk("awready", 32'(axi.AWREADY), 32'(!m_bpend && axi.AWVALID && axi.WVALID && !rst));
      chk("wready",  32'(axi.WREADY),  32'(!m_bpend && axi.AWVALID && axi.WVALID && !rst));
      chk("bvalid",  32'(axi.BVALID),  32'(m_bpend));
      if (m_bpend) chk("bresp", 32'(axi.BRESP), 32'(m_bresp));
      chk("arready", 32'(axi.ARREADY), 32'(!m_rpend && axi.ARVALID && !rst));
      chk("rvalid",  32'(axi.RVALID),  32'(m_rpend));
      if (m_rpend) begin
         chk("rdata", axi.RDATA, m_rdata);
         chk("rresp", 32'(axi.RRESP), 32'(m_rresp));
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [NUM_CH*SW-1:0] mk(input logic [15:0] c0, input logic [15:0] c1,
                                               input logic [15:0] base);
      logic [NUM_CH*SW-1:0] v = '0;
      v[0 +: SW]  = c0;
      v[SW +: SW] = c1;
      for (int k = 2; k < NUM_CH; k++) v[k*SW +: SW] = base + 16'(k);
      return v;
   endfunction

   task automatic strobe(input logic [NUM_CH*SW-1:0] sd);
      sample_data  = sd;
      sample_valid = 1'b1;
      @(posedge clk); #1;
      sample_valid = 1'b0;
   endtask

   task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            input bit with_strobe, input logic [NUM_CH*SW-1:0] sd,
                            output logic [1:0] resp);
      bit ok = 0;
      resp = 2'bxx;
      axi.AWADDR = a; axi.WDATA = d; axi.WSTRB = s;
      axi.AWVALID = 1'b1; axi.WVALID = 1'b1; axi.BREADY = 1'b1;
      if (with_strobe) begin sample_data = sd; sample_valid = 1'b1; end
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (axi.AWREADY) begin ok = 1; break; end
      end
      @(posedge clk); #1;
      axi.AWVALID = 1'b0; axi.WVALID = 1'b0; sample_valid = 1'b0;
      chk("write_accept_timeout", 32'(ok), 32'd1);
      ok = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (axi.BVALID) begin ok = 1; resp = axi.BRESP; break; end
      end
      chk("write_resp_timeout", 32'(ok), 32'd1);
      @(posedge clk); #1;
      axi.BREADY = 1'b0;
   endtask

   task automatic axi_read(input logic [AW-1:0] a, input int hold,
                           output logic [31:0] d, output logic [1:0] resp);
      bit ok = 0;
      d = 32'hxxxxxxxx; resp = 2'bxx;
      axi.ARADDR = a; axi.ARVALID = 1'b1; axi.RREADY = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (axi.ARREADY) begin ok = 1; break; end
      end
      @(posedge clk); #1;
      axi.ARVALID = 1'b0;
      chk("read_accept_timeout", 32'(ok), 32'd1);
      ok = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (axi.RVALID) begin ok = 1; d = axi.RDATA; resp = axi.RRESP; break; end
      end
      chk("read_data_timeout", 32'(ok), 32'd1);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("rvalid_hold", 32'(axi.RVALID), 32'd1);
         chk("rdata_hold",  axi.RDATA, d);
      end
      @(posedge clk); #1;
      axi.RREADY = 1'b1;
      @(posedge clk); #1;
      axi.RREADY = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   logic [31:0] rd;
   logic [1:0]  rs, bs;
   logic [NUM_CH*SW-1:0] zero_sd = '0;

   initial begin
      axi.AWADDR = '0; axi.AWVALID = 1'b0; axi.WDATA = '0; axi.WSTRB = '0; axi.WVALID = 1'b0;
      axi.BREADY = 1'b0; axi.ARADDR = '0; axi.ARVALID = 1'b0; axi.RREADY = 1'b0;
      sample_valid = 1'b0; sample_data = '0;
      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset values
      axi_read(7'h00, 0, rd, rs); chk("rst_ctrl", rd, 32'd0);  chk("rst_ctrl_resp", 32'(rs), 32'd0);
      axi_read(7'h04, 0, rd, rs); chk("rst_div", rd, 32'd10);  chk("rst_div_resp", 32'(rs), 32'd0);
      axi_read(7'h08, 0, rd, rs); chk("rst_status", rd, 32'd0);
      axi_read(7'h0C, 0, rd, rs); chk("rst_seq", rd, 32'd0);   chk("rst_seq_resp", 32'(rs), 32'd0);

      // Enable + irq_en, first capture
      axi_write(7'h00, 32'h5, 4'hF, 0, zero_sd, bs); chk("ctrl_bresp", 32'(bs), 32'd0);
      strobe(mk(16'h8001, 16'h0002, 16'hC000));
      @(negedge clk); chk("irq_lag", 32'(irq), 32'd0);
      @(negedge clk); chk("irq_set", 32'(irq), 32'd1);
      @(posedge clk); #1;
      axi_read(7'h10, 0, rd, rs); chk("ch0", rd, 32'hFFFF8001);
      axi_read(7'h14, 0, rd, rs); chk("ch1", rd, 32'h00000002);
      axi_read(7'h2C, 0, rd, rs); chk("ch7", rd, 32'hFFFFC007);
      axi_read(7'h0C, 0, rd, rs); chk("seq1", rd, 32'd1);
      axi_read(7'h08, 0, rd, rs); chk("status_new", rd, 32'd1);

      // Overrun, W1C, W1C colliding with a capture
      strobe(mk(16'h1234, 16'h0005, 16'h0100));
      axi_read(7'h08, 0, rd, rs); chk("status_ovr", rd, 32'd3);
      axi_write(7'h08, 32'h1, 4'hF, 0, zero_sd, bs);
      axi_read(7'h08, 0, rd, rs); chk("status_w1c", rd, 32'd2);
      axi_write(7'h08, 32'h1, 4'hF, 1, mk(16'h7FFF, 16'hFFFF, 16'h0200), bs);
      axi_read(7'h08, 0, rd, rs); chk("status_set_wins", rd, 32'd3);
      axi_read(7'h0C, 0, rd, rs); chk("seq3", rd, 32'd3);
      axi_read(7'h14, 0, rd, rs); chk("ch1_neg1", rd, 32'hFFFFFFFF);

      // Read of a channel in the same cycle as a capture returns the old sample
      fork
         axi_read(7'h10, 0, rd, rs);
         strobe(mk(16'h0042, 16'h0043, 16'h0300));
      join
      chk("ch0_pre_capture", rd, 32'h00007FFF);
      axi_read(7'h10, 0, rd, rs); chk("ch0_post_capture", rd, 32'h00000042);

      // Freeze blocks capture; partial DIV write; RO and out-of-range writes
      axi_write(7'h00, 32'h7, 4'hF, 0, zero_sd, bs);
      strobe(mk(16'hDEAD, 16'hBEEF, 16'h0400));
      axi_read(7'h10, 0, rd, rs); chk("ch0_frozen", rd, 32'h00000042);
      axi_read(7'h0C, 0, rd, rs); chk("seq_frozen", rd, 32'd4);
      axi_write(7'h04, 32'hABCD, 4'b0001, 0, zero_sd, bs);
      axi_read(7'h04, 0, rd, rs); chk("div_strb", rd, 32'h000000CD);
      axi_write(7'h0C, 32'hFFFF, 4'hF, 0, zero_sd, bs); chk("ro_bresp", 32'(bs), 32'd0);
      axi_write(7'h30, 32'h1, 4'hF, 0, zero_sd, bs);    chk("oor_bresp", 32'(bs), 32'd2);
      axi_read(7'h0C, 0, rd, rs); chk("seq_ro", rd, 32'd4);

      // Out-of-range read with RREADY held low
      axi_read(7'h30, 5, rd, rs);
      chk("oor_rresp", 32'(rs), 32'd2);
      chk("oor_rdata", rd, 32'd0);

      // Reset while a write response is pending
      axi.AWADDR = 7'h00; axi.WDATA = 32'h1; axi.WSTRB = 4'hF;
      axi.AWVALID = 1'b1; axi.WVALID = 1'b1; axi.BREADY = 1'b0;
      @(posedge clk); #1;
      axi.AWVALID = 1'b0; axi.WVALID = 1'b0;
      @(negedge clk); chk("bvalid_pending", 32'(axi.BVALID), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_bvalid_drop", 32'(axi.BVALID), 32'd0);
      chk("rst_enable", 32'(enable_out), 32'd0);
      chk("rst_divider", 32'(divider_out), 32'd10);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      axi_write(7'h04, 32'h1234, 4'hF, 0, zero_sd, bs); chk("post_rst_bresp", 32'(bs), 32'd0);
      axi_read(7'h04, 0, rd, rs); chk("post_rst_div", rd, 32'h1234);
      axi_read(7'h00, 0, rd, rs); chk("post_rst_ctrl", rd, 32'd0);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
